// File: rtl/tx_byte_framing.sv
// TX framing: MAC frame words become a continuous 32-lane XGMII stream with
// /S/+preamble+SFD, an 8-lane payload shift, /T/ termination, /I/ fill and a minimum IPG.

module tx_lane_term #(
    parameter int LANE = 0
) (
    input  logic [7:0] byte_in,
    input  logic       ctrl_in,
    input  logic       term_en,
    input  logic [5:0] term_lane,
    output logic [7:0] byte_out,
    output logic       ctrl_out
);
    localparam logic [5:0] LANE_IDX = 6'(LANE);

    always_comb begin
        byte_out = byte_in;
        ctrl_out = ctrl_in;
        if (term_en && LANE_IDX == term_lane) begin
            byte_out = 8'hFD;
            ctrl_out = 1'b1;
        end else if (term_en && LANE_IDX > term_lane) begin
            byte_out = 8'h07;
            ctrl_out = 1'b1;
        end
    end
endmodule

module tx_byte_framing #(
    parameter int DATA_WIDTH = 256,
    parameter int CTRL_WIDTH = 32,
    parameter int IPG_MIN    = 12
) (
    input  logic                  x_clk,
    input  logic                  reset_,
    input  logic                  fmac_txd_en,
    input  logic                  linkup,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  in_eof,
    input  logic [5:0]            in_nbytes,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] txd,
    output logic [CTRL_WIDTH-1:0] txc,
    output logic                  tx_busy,
    input  logic                  cnt_clr,
    output logic [31:0]           TX_FRAME_CNT,
    output logic [15:0]           TX_UNDERRUN_CNT
);
    localparam int NUM_LANES = CTRL_WIDTH;
    localparam int RES_W     = 64;
    // an eof word with more valid bytes than this puts /T/ too close to the word end
    localparam int IPG_NB_THR = NUM_LANES - 8 - IPG_MIN;

    localparam logic [NUM_LANES-1:0][7:0] IDLE_WORD = {NUM_LANES{8'h07}};
    localparam logic [NUM_LANES-1:0][7:0] ERR_WORD  = {NUM_LANES{8'hFE}};
    localparam logic [RES_W-1:0]          PREAMBLE  = 64'hD555_5555_5555_55FB;

    typedef enum logic [2:0] {IDLE, DATA, TAIL, IPG, DRAIN} state_t;

    state_t                         state, state_nxt;
    logic [RES_W-1:0]               res, res_nxt;
    logic [5:0]                     tail_t, tail_t_nxt;
    logic [5:0]                     n_eff;
    logic                           accept, load, frame_inc, undr_inc;
    logic                           term_en;
    logic [5:0]                     term_lane;
    logic [NUM_LANES-1:0][7:0]      base_d, term_d, txd_q;
    logic [NUM_LANES-1:0]           base_c, term_c, txc_q;

    always_comb begin
        case (state)
            IDLE:        in_ready = fmac_txd_en & linkup;
            DATA, DRAIN: in_ready = 1'b1;
            default:     in_ready = 1'b0;
        endcase
        in_ready = in_ready & reset_;
    end

    assign accept  = in_valid & in_ready;
    assign n_eff   = (in_nbytes == 6'd0) ? 6'd32 : in_nbytes;
    assign tx_busy = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        res_nxt    = res;
        tail_t_nxt = tail_t;
        base_d     = IDLE_WORD;
        base_c     = '1;
        term_en    = 1'b0;
        term_lane  = '0;
        load       = 1'b0;
        frame_inc  = 1'b0;
        undr_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && in_sof) begin
                    base_d = {in_data[DATA_WIDTH-RES_W-1:0], PREAMBLE};
                    base_c = {{(NUM_LANES-8){1'b0}}, 8'h01};
                    load   = 1'b1;
                end
            end
            DATA: begin
                if (in_valid) begin
                    base_d = {in_data[DATA_WIDTH-RES_W-1:0], res};
                    base_c = '0;
                    load   = 1'b1;
                end else begin
                    base_d    = ERR_WORD;
                    undr_inc  = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            TAIL: begin
                base_d    = {{(DATA_WIDTH-RES_W){1'b0}}, res};
                base_c    = '0;
                term_en   = 1'b1;
                term_lane = tail_t;
                frame_inc = 1'b1;
                state_nxt = IDLE;
            end
            IPG:   state_nxt = IDLE;
            DRAIN: if (accept && in_eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // shared by the sof word and DATA words: carry bytes 24..31, handle eof
        if (load) begin
            res_nxt   = in_data[DATA_WIDTH-1:DATA_WIDTH-RES_W];
            state_nxt = DATA;
            if (in_eof) begin
                if (n_eff <= 6'd23) begin
                    term_en   = 1'b1;
                    term_lane = n_eff + 6'd8;
                    frame_inc = 1'b1;
                    state_nxt = (int'(n_eff) > IPG_NB_THR) ? IPG : IDLE;
                end else begin
                    tail_t_nxt = n_eff - 6'd24;
                    state_nxt  = TAIL;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tx_lane_term #(.LANE(i)) u_lane (
            .byte_in   (base_d[i]),
            .ctrl_in   (base_c[i]),
            .term_en   (term_en),
            .term_lane (term_lane),
            .byte_out  (term_d[i]),
            .ctrl_out  (term_c[i])
        );
    end

    always_ff @(posedge x_clk or negedge reset_) begin
        if (!reset_) begin
            state  <= IDLE;
            res    <= '0;
            tail_t <= '0;
            txd_q  <= IDLE_WORD;
            txc_q  <= '1;
        end else begin
            state  <= state_nxt;
            res    <= res_nxt;
            tail_t <= tail_t_nxt;
            txd_q  <= term_d;
            txc_q  <= term_c;
        end
    end

    always_ff @(posedge x_clk or negedge reset_) begin
        if (!reset_) begin
            TX_FRAME_CNT    <= '0;
            TX_UNDERRUN_CNT <= '0;
        end else begin
            if (cnt_clr)
                TX_FRAME_CNT <= '0;
            else if (frame_inc)
                TX_FRAME_CNT <= TX_FRAME_CNT + 32'd1;
            if (cnt_clr)
                TX_UNDERRUN_CNT <= '0;
            else if (undr_inc && TX_UNDERRUN_CNT != 16'hFFFF)
                TX_UNDERRUN_CNT <= TX_UNDERRUN_CNT + 16'd1;
        end
    end

    assign txd = txd_q;
    assign txc = txc_q;
endmodule

// File: tb/tb_tx_byte_framing.sv
// Scoreboard bench for tx_byte_framing: expected XGMII words are built from a
// byte-stream view of each frame and compared one per cycle on the falling edge.

module tb_tx_byte_framing;
    typedef struct {
        logic [255:0] d;
        logic [31:0]  c;
        string        tag;
    } exp_t;

    logic         x_clk = 1'b0;
    logic         reset_ = 1'b1;
    logic         fmac_txd_en = 1'b1;
    logic         linkup = 1'b1;
    logic [255:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic         in_eof = 1'b0;
    logic [5:0]   in_nbytes = '0;
    logic         cnt_clr = 1'b0;
    logic         in_ready;
    logic [255:0] txd;
    logic [31:0]  txc;
    logic         tx_busy;
    logic [31:0]  TX_FRAME_CNT;
    logic [15:0]  TX_UNDERRUN_CNT;

    tx_byte_framing dut (
        .x_clk           (x_clk),
        .reset_          (reset_),
        .fmac_txd_en     (fmac_txd_en),
        .linkup          (linkup),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_sof          (in_sof),
        .in_eof          (in_eof),
        .in_nbytes       (in_nbytes),
        .in_ready        (in_ready),
        .txd             (txd),
        .txc             (txc),
        .tx_busy         (tx_busy),
        .cnt_clr         (cnt_clr),
        .TX_FRAME_CNT    (TX_FRAME_CNT),
        .TX_UNDERRUN_CNT (TX_UNDERRUN_CNT)
    );

    always #5 x_clk = ~x_clk;

    int           checks = 0;
    int           errors = 0;
    int           exp_frames = 0;
    exp_t         exp_q[$];
    exp_t         fq[$];
    logic [255:0] iq[$];
    int           last_n;
    bit           ipg_pend = 1'b0;
    bit           nxt_pend;
    exp_t         mon_e;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge x_clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.tag, {txc, txd}, {mon_e.c, mon_e.d});
        end
    end

    function automatic exp_t mk_word(input logic [7:0] b, input string tag);
        exp_t e;
        e.d   = {32{b}};
        e.c   = '1;
        e.tag = tag;
        return e;
    endfunction

    task automatic step(input exp_t e);
        @(posedge x_clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic in_idle();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_eof    = 1'b0;
        in_nbytes = '0;
        cnt_clr   = 1'b0;
    endtask

    // Lay the frame out as a byte stream and slice it into 32-byte output words.
    task automatic build(input int len, input logic [7:0] base);
        logic [7:0]   bq[$];
        bit           kq[$];
        int           nw, tlane, idx;
        exp_t         o;
        logic [255:0] d;
        fq.delete();
        iq.delete();
        bq.push_back(8'hFB); kq.push_back(1'b1);
        repeat (6) begin bq.push_back(8'h55); kq.push_back(1'b0); end
        bq.push_back(8'hD5); kq.push_back(1'b0);
        for (int j = 0; j < len; j++) begin bq.push_back(base + 8'(j)); kq.push_back(1'b0); end
        tlane = bq.size() % 32;
        bq.push_back(8'hFD); kq.push_back(1'b1);
        while (bq.size() % 32 != 0) begin bq.push_back(8'h07); kq.push_back(1'b1); end
        for (int w = 0; w < bq.size() / 32; w++) begin
            for (int l = 0; l < 32; l++) begin
                o.d[8*l +: 8] = bq[32*w + l];
                o.c[l]        = kq[32*w + l];
            end
            o.tag = $sformatf("len%0d_w%0d", len, w);
            fq.push_back(o);
        end
        nw     = (len + 31) / 32;
        last_n = len - 32 * (nw - 1);
        for (int w = 0; w < nw; w++) begin
            for (int l = 0; l < 32; l++) begin
                idx = 32*w + l;
                d[8*l +: 8] = (idx < len) ? base + 8'(idx) : 8'hAA;
            end
            iq.push_back(d);
        end
        nxt_pend = (32 - tlane) < 12;
    endtask

    task automatic drive_frame(input string nm, input bit drop_en, input bit clr_eof, input bit zero32);
        int nw;
        nw = iq.size();
        if (ipg_pend) begin
            in_valid = 1'b1; in_data = iq[0]; in_sof = 1'b1; in_eof = (nw == 1);
            in_nbytes = 6'(last_n);
            #1 chk({nm, "_ipg_rdy"}, 288'(in_ready), 288'(0));
            step(mk_word(8'h07, {nm, "_ipg_word"}));
        end
        for (int w = 0; w < nw; w++) begin
            in_valid = 1'b1;
            in_data  = iq[w];
            in_sof   = (w == 0);
            in_eof   = (w == nw - 1);
            in_nbytes = (w != nw - 1) ? 6'd3 : ((last_n == 32 && zero32) ? 6'd0 : 6'(last_n));
            cnt_clr  = clr_eof && (w == nw - 1);
            #1 chk({nm, "_rdy"}, 288'(in_ready), 288'(1));
            step(fq[w]);
            if (drop_en && w == 0) fmac_txd_en = 1'b0;
        end
        in_idle();
        if (fq.size() > nw) begin
            #1 chk({nm, "_tail_rdy"}, 288'(in_ready), 288'(0));
            step(fq[nw]);
        end
        exp_frames = clr_eof ? 0 : exp_frames + 1;
        ipg_pend   = nxt_pend;
        chk({nm, "_fcnt"}, 288'(TX_FRAME_CNT), 288'(exp_frames));
    endtask

    task automatic send_frame(input string nm, input int len, input logic [7:0] base);
        build(len, base);
        drive_frame(nm, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        in_idle();
        step(mk_word(8'h07, "settle"));
        ipg_pend = 1'b0;
    endtask

    initial begin
        #1 reset_ = 1'b0;
        #2;
        chk("rst_word", {txc, txd}, {32'hFFFF_FFFF, {32{8'h07}}});
        chk("rst_rdy", 288'(in_ready), 288'(0));
        chk("rst_fcnt", 288'(TX_FRAME_CNT), 288'(0));
        chk("rst_ucnt", 288'(TX_UNDERRUN_CNT), 288'(0));
        chk("rst_busy", 288'(tx_busy), 288'(0));
        #9 reset_ = 1'b1;

        send_frame("single10", 10, 8'h00);
        chk("single10_busy", 288'(tx_busy), 288'(0));
        send_frame("frame64", 64, 8'h00);
        send_frame("ipg20", 20, 8'h10);
        send_frame("ipg12", 12, 8'h20);
        send_frame("imm40", 40, 8'h30);
        send_frame("n23", 55, 8'h50);
        send_frame("n13", 13, 8'h60);
        send_frame("tail24", 56, 8'h70);
        build(32, 8'h90);
        drive_frame("nb0", 1'b0, 1'b0, 1'b1);
        if (ipg_pend) settle();

        // gating: en low, then link low, then enabled start
        build(10, 8'h80);
        fmac_txd_en = 1'b0;
        in_valid = 1'b1; in_data = iq[0]; in_sof = 1'b1; in_eof = 1'b1; in_nbytes = 6'd10;
        #1 chk("gate_rdy", 288'(in_ready), 288'(0));
        step(mk_word(8'h07, "gate_idle0"));
        step(mk_word(8'h07, "gate_idle1"));
        fmac_txd_en = 1'b1; linkup = 1'b0;
        #1 chk("link_rdy", 288'(in_ready), 288'(0));
        step(mk_word(8'h07, "link_idle"));
        linkup = 1'b1;
        drive_frame("gate", 1'b0, 1'b0, 1'b0);
        build(70, 8'hA0);
        drive_frame("dropen", 1'b1, 1'b0, 1'b0);
        fmac_txd_en = 1'b1;
        if (ipg_pend) settle();

        // underrun: one bubble after the sof word, rest drained as idle
        build(96, 8'hC0);
        in_valid = 1'b1; in_data = iq[0]; in_sof = 1'b1; in_eof = 1'b0;
        step(fq[0]);
        in_idle();
        step(mk_word(8'hFE, "undr_err"));
        in_valid = 1'b1; in_data = iq[1];
        #1 chk("drain_rdy", 288'(in_ready), 288'(1));
        step(mk_word(8'h07, "drain_w1"));
        in_data = iq[2]; in_eof = 1'b1; in_nbytes = 6'd0;
        step(mk_word(8'h07, "drain_w2"));
        in_idle();
        chk("undr_ucnt", 288'(TX_UNDERRUN_CNT), 288'(1));
        chk("undr_fcnt", 288'(TX_FRAME_CNT), 288'(exp_frames));
        chk("undr_busy", 288'(tx_busy), 288'(0));

        // async reset in the middle of a frame
        build(96, 8'hE0);
        in_valid = 1'b1; in_data = iq[0]; in_sof = 1'b1; in_eof = 1'b0;
        step(fq[0]);
        in_data = iq[1]; in_sof = 1'b0;
        @(negedge x_clk);
        #1 reset_ = 1'b0;
        #1;
        chk("mid_rst_word", {txc, txd}, {32'hFFFF_FFFF, {32{8'h07}}});
        chk("mid_rst_fcnt", 288'(TX_FRAME_CNT), 288'(0));
        chk("mid_rst_ucnt", 288'(TX_UNDERRUN_CNT), 288'(0));
        chk("mid_rst_rdy", 288'(in_ready), 288'(0));
        in_idle();
        #1 reset_ = 1'b1;
        exp_frames = 0;
        ipg_pend   = 1'b0;
        send_frame("post_rst", 10, 8'h05);

        build(10, 8'h44);
        drive_frame("clr_eof", 1'b0, 1'b1, 1'b0);

        in_idle();
        step(mk_word(8'h07, "end_idle0"));
        step(mk_word(8'h07, "end_idle1"));
        @(negedge x_clk);
        #1;
        chk("sb_empty", 288'(exp_q.size()), 288'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_byte_framing.md
Name: tx_byte_framing

Overview:
- Transmit-side counterpart of the receive byte-reordering path. Runs on x_clk.
- Accepts MAC TX frame words (256-bit, lane 0 = bits[7:0], with sof/eof/valid-byte-count) over a valid/ready handshake.
- Emits a continuous 32-lane XGMII-style data/ctrl stream. Each frame: /S/ + preamble + SFD, payload shifted 8 lanes, /T/ after the last byte, /I/ fill, minimum IPG enforced.
- Sits between the TX frame FIFO and the XAUI/PCS transmit interface.

Parameters:
- DATA_WIDTH, 256, output data width; 32 lanes. Only 256 is supported.
- CTRL_WIDTH, 32, one ctrl bit per lane.
- IPG_MIN, 12, minimum bytes from /T/ (inclusive) to the next /S/.

Ports:
- x_clk  in  1  sole clock.
- reset_  in  1  asynchronous, active-low reset.
- fmac_txd_en  in  1  permits starting new frames.
- linkup  in  1  link status; a frame starts only when high.
- in_data  in  256  frame bytes.
- in_valid  in  1  in_data/in_sof/in_eof/in_nbytes valid.
- in_sof  in  1  first word of frame.
- in_eof  in  1  last word of frame.
- in_nbytes  in  6  valid bytes in eof word, 1..32 (0 treated as 32); ignored unless in_eof.
- in_ready  out  1  word accepted when in_valid & in_ready.
- txd  out  256  XGMII data, registered.
- txc  out  32  XGMII ctrl, bit i for lane i, registered.
- tx_busy  out  1  state != IDLE.
- cnt_clr  in  1  synchronous clear of both counters; has priority over increment.
- TX_FRAME_CNT  out  32  frames terminated with /T/; wraps.
- TX_UNDERRUN_CNT  out  16  underrun events; saturates at 0xFFFF.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; residual register cleared.
  - txd = {32{8'h07}}, txc = 32'hFFFFFFFF (idle word).
  - Counters = 0; in_ready = 0 while reset_ low.
- Latency: a word accepted at cycle N affects txd/txc at N+1. Every cycle drives one output word; no gaps.
- Code bytes: /S/=0xFB, /T/=0xFD, /I/=0x07, /E/=0xFE, all with txc=1. Preamble 0x55 and SFD 0xD5 have txc=0.
- in_ready is combinational from state and inputs:
  - IDLE: fmac_txd_en & linkup.
  - DATA: 1.
  - TAIL, IPG, DRAIN: TAIL=0, IPG=0, DRAIN=1.
- Residual register R holds 8 bytes carried forward. Each data word out = {in bytes 0..23 in lanes 8..31, R in lanes 0..7}; R <= in bytes 24..31.
- IDLE:
  - Output the idle word.
  - Accept with in_sof: output lanes 0..7 = FB,55,55,55,55,55,55,D5 with txc bits 0..7 = 1,0,0,0,0,0,0,0; lanes 8..31 = payload.
  - Accept without in_sof: discard the word; no output change.
- DATA, or the sof word itself, when in_eof is accepted with n = in_nbytes:
  - n<=23: /T/ at lane t=8+n; lanes >t = /I/; frame count +1. Next state IPG if 32-t < IPG_MIN (n>=13), else IDLE.
  - n>=24: full data word out; next state TAIL.
- TAIL: R bytes 0..n-25 in lanes 0..n-25, /T/ at lane n-24, /I/ after; frame count +1; next state IDLE. The IPG rule is always satisfied here.
- IPG: output one idle word; next state IDLE.
- Underrun: in DATA with in_valid=0:
  - Output all 32 lanes /E/ (txc=all 1s).
  - TX_UNDERRUN_CNT +1 (saturating); frame not counted; next state DRAIN.
- DRAIN: output idle; accept and discard words until an in_eof word is accepted, then IDLE.
- sof inside DATA: treated as data; not re-framed.
- fmac_txd_en/linkup deassert mid-frame: the current frame completes normally; the gate applies only in IDLE.
- Simultaneous cnt_clr and increment: counter = 0.
- Async reset mid-frame: the output becomes the idle word immediately; no /T/ is emitted. The frame is abandoned and not counted.

Test Plan:
- Single-word frame: sof+eof, n=10, data bytes 0x00..0x09 → next cycle lanes 0..7 preamble as above, lanes 8..17 = 00..09, lane 18 = FD (txc bit 18=1), lanes 19..31 = 07; state returns to IDLE; TX_FRAME_CNT=1.
- 64-byte frame (2 words, eof n=32) → 3 output words; word 3 has bytes 0x38..0x3F in lanes 0..7, FD at lane 8, 07 after; in_ready=0 during TAIL; count +1.
- IPG: eof n=20 (/T/ at lane 28) → one extra all-idle word before the next /S/, even with in_valid held high; n=12 (/T/ at 20) → the next sof is accepted immediately.
- Underrun: drop in_valid for 1 cycle mid-frame → one all-FE word (txc=FFFFFFFF); UNDERRUN_CNT=1; remaining words to eof are consumed with idle output; FRAME_CNT unchanged.
- Gating: fmac_txd_en=0 with a pending sof → in_ready=0 and idle output; assert fmac_txd_en → start word on the following cycle. Deassert it mid-frame → the frame still terminates.
- Reset mid-DATA plus cnt_clr: pulse reset_ low → the idle word appears without waiting for a clock edge, counters read 0, and the next sof frames correctly. cnt_clr asserted together with the eof word → FRAME_CNT=0.
